cache_miss_ctrl: RTL and testbench

Miss-handling sequencer for the 2-way, 128-set, 32-byte-line cache. It sits between the tag/data arrays and the AXI bridge. On a tag-array miss it optionally writes back the victim line, burst-refills the new line, and then pulses `refresh` so the tag array installs the new tag and flips LRU. It is instantiated once per cache (I and D).

---
 rtl/cache_miss_ctrl.sv | 153 +++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss sequencer for the cache: optional victim write-back, line refill, then a refresh pulse.
// Define CACHE_MISS_WB_OVERLAP_EN to run the refill read in parallel with the victim write-back.
module cache_miss_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss,
    input  logic             write_back,
    input  logic [31:0]      raddr,
    input  logic [31:0]      waddr,
    output logic             rd_req,
    output logic [31:0]      rd_addr,
    output logic [3:0]       rd_len,
    input  logic             rd_addr_ok,
    input  logic             rd_valid,
    input  logic [31:0]      rd_data,
    output logic             wr_req,
    output logic [31:0]      wr_addr,
    input  logic             wr_addr_ok,
    input  logic             wr_beat_ok,
    output logic [IDX_W-1:0] wr_idx,
    output logic             wr_last,
    input  logic             wr_done,
    output logic             refill_we,
    output logic [IDX_W-1:0] refill_idx,
    output logic [31:0]      refill_wdata,
    output logic             refresh,
    output logic             busy
);
    // state   | meaning
    // IDLE    | waiting for a miss; addresses latched on exit
    // WB_ADDR | victim write address request
    // WB_DATA | victim beats, wr_idx = beat counter
    // WB_RESP | waiting for the write response
    // RD_ADDR | refill read address request
    // RD_DATA | refill beats written into the data array
    // REFRESH | one-cycle tag/LRU install pulse
    // SETTLE  | miss ignored while the new tag becomes visible
    typedef enum logic [2:0] {
        IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, REFRESH, SETTLE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [3:0]       BURST_LEN = 4'(LINE_WORDS - 1);

    state_t           state, state_nxt;
    logic [31:0]      raddr_q, waddr_q;
    logic [IDX_W-1:0] wr_cnt, rd_cnt;
    logic             rd_req_c, rd_data_c, rd_last_beat;

`ifdef CACHE_MISS_WB_OVERLAP_EN
    // Read side of an overlapped dirty miss, tracked alongside the write-back states.
    typedef enum logic [1:0] {OV_IDLE, OV_ADDR, OV_DATA, OV_DONE} ov_t;
    ov_t  ov_rd, ov_rd_nxt;
    logic wr_done_seen, rd_fill_done;

    always_comb begin
        ov_rd_nxt = ov_rd;
        case (ov_rd)
            OV_IDLE: if (state == WB_ADDR && wr_addr_ok) ov_rd_nxt = OV_ADDR;
            OV_ADDR: if (rd_addr_ok) ov_rd_nxt = OV_DATA;
            OV_DATA: if (rd_valid && rd_cnt == LAST_IDX) ov_rd_nxt = OV_DONE;
            default: ov_rd_nxt = ov_rd;
        endcase
        if (state == IDLE) ov_rd_nxt = OV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_rd        <= OV_IDLE;
            wr_done_seen <= 1'b0;
        end else begin
            ov_rd <= ov_rd_nxt;
            if (state == IDLE)
                wr_done_seen <= 1'b0;
            else if (state == WB_RESP && wr_done)
                wr_done_seen <= 1'b1;
        end
    end

    assign rd_req_c     = (state == RD_ADDR) || (ov_rd == OV_ADDR);
    assign rd_data_c    = (state == RD_DATA) || (ov_rd == OV_DATA);
    assign rd_fill_done = (ov_rd == OV_DONE) || ((ov_rd == OV_DATA) && rd_last_beat);
`else
    assign rd_req_c  = (state == RD_ADDR);
    assign rd_data_c = (state == RD_DATA);
`endif

    assign rd_last_beat = rd_data_c && rd_valid && (rd_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss) state_nxt = write_back ? WB_ADDR : RD_ADDR;
            WB_ADDR: if (wr_addr_ok) state_nxt = WB_DATA;
            WB_DATA: if (wr_beat_ok && wr_cnt == LAST_IDX) state_nxt = WB_RESP;
`ifdef CACHE_MISS_WB_OVERLAP_EN
            WB_RESP: if ((wr_done || wr_done_seen) && rd_fill_done) state_nxt = REFRESH;
`else
            WB_RESP: if (wr_done) state_nxt = RD_ADDR;
`endif
            RD_ADDR: if (rd_addr_ok) state_nxt = RD_DATA;
            RD_DATA: if (rd_last_beat) state_nxt = REFRESH;
            REFRESH: state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_q <= '0;
            waddr_q <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (state == IDLE && miss) begin
                raddr_q <= raddr;
                waddr_q <= waddr;
            end
            if (state == IDLE || (state == WB_ADDR && wr_addr_ok))
                wr_cnt <= '0;
            else if (state == WB_DATA && wr_beat_ok)
                wr_cnt <= wr_cnt + 1'b1;
            if (state == IDLE || (rd_req_c && rd_addr_ok))
                rd_cnt <= '0;
            else if (rd_data_c && rd_valid)
                rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_comb begin
        rd_req       = rd_req_c;
        rd_addr      = rd_req_c ? raddr_q : '0;
        rd_len       = BURST_LEN;
        wr_req       = (state == WB_ADDR);
        wr_addr      = (state == WB_ADDR) ? waddr_q : '0;
        wr_idx       = wr_cnt;
        wr_last      = (state == WB_DATA) && (wr_cnt == LAST_IDX);
        refill_we    = rd_data_c && rd_valid;
        refill_idx   = rd_cnt;
        refill_wdata = (rd_data_c && rd_valid) ? rd_data : '0;
        refresh      = (state == REFRESH);
        busy         = (state != IDLE);
    end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: table of zero-wait misses, random back-pressure misses and a mid-refill reset,
// all checked against a transaction-level model of the AXI handshakes.
module tb_cache_miss_ctrl;
    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss = 1'b0, write_back = 1'b0;
    logic [31:0] raddr = '0, waddr = '0;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [3:0]  rd_len;
    logic        rd_addr_ok = 1'b0, rd_valid = 1'b0;
    logic [31:0] rd_data = '0;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_addr_ok = 1'b0, wr_beat_ok = 1'b0, wr_done = 1'b0;
    logic [2:0]  wr_idx, refill_idx;
    logic        wr_last, refill_we, refresh, busy;
    logic [31:0] refill_wdata;

    int n_cmp = 0;
    int n_err = 0;

    cache_miss_ctrl #(.LINE_WORDS(LW), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .miss(miss), .write_back(write_back),
        .raddr(raddr), .waddr(waddr),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_addr_ok(rd_addr_ok), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_addr_ok(wr_addr_ok),
        .wr_beat_ok(wr_beat_ok), .wr_idx(wr_idx), .wr_last(wr_last), .wr_done(wr_done),
        .refill_we(refill_we), .refill_idx(refill_idx), .refill_wdata(refill_wdata),
        .refresh(refresh), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic int rnd(input int m);
        return (m <= 0) ? 0 : int'($urandom % 32'(m + 1));
    endfunction

    task automatic check_reset_outputs();
        chk("rst_rd_req", 32'(rd_req), 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_len", 32'(rd_len), LW - 1);
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_idx", 32'(wr_idx), 0);
        chk("rst_wr_last", 32'(wr_last), 0);
        chk("rst_refill_we", 32'(refill_we), 0);
        chk("rst_refill_idx", 32'(refill_idx), 0);
        chk("rst_refill_wdata", refill_wdata, 0);
        chk("rst_refresh", 32'(refresh), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    // One complete miss; the bench plays the AXI slave with 0..maxw wait cycles per handshake.
    // Entered and left at posedge+1 with the DUT idle; tr returns the cycle of refresh (miss cycle = 0).
    task automatic run_miss(input logic wb, input logic hold, input logic early_b,
                            input logic [31:0] ra, input logic [31:0] wa, input int maxw,
                            input logic [31:0] dbase, output int tr);
        int          ar_w, r_w, aw_w, w_w, b_w, rbeats, wbeats, n_ref;
        logic        ar_done, aw_done, b_done, early_sent, fin;
        logic        ar_ack, aw_ack, r_fire, w_fire, b_fire, rd_pend, wr_pend;
        logic [31:0] rd_addr_prev, wr_addr_prev;
        ar_w = rnd(maxw); r_w = rnd(maxw); aw_w = rnd(maxw); w_w = rnd(maxw); b_w = rnd(maxw);
        rbeats = 0; wbeats = 0; n_ref = 0; tr = -1;
        ar_done = 0; aw_done = 0; b_done = 0; early_sent = 0; fin = 0; rd_pend = 0; wr_pend = 0;
        rd_addr_prev = '0; wr_addr_prev = '0;
        write_back = wb; raddr = ra; waddr = wa;
        for (int cyc = 0; cyc < 400; cyc++) begin
            miss = (cyc == 0) || (hold && !(tr >= 0 && cyc >= tr + 2));
            if (cyc == 1) begin
                raddr = ~ra;
                waddr = ~wa;
                if (!hold) write_back = ~wb;
            end
            rd_addr_ok = 0; rd_valid = 0; rd_data = $urandom;
            wr_addr_ok = 0; wr_beat_ok = 0; wr_done = 0;
            ar_ack = 0; aw_ack = 0; r_fire = 0; w_fire = 0; b_fire = 0;
            if (rd_req) begin
                if (ar_w == 0) begin rd_addr_ok = 1; ar_ack = 1; end
                else ar_w--;
            end
            if (ar_done && rbeats < LW) begin
                if (r_w == 0) begin
                    rd_valid = 1; rd_data = dbase + 32'(rbeats); r_fire = 1; r_w = rnd(maxw);
                end else r_w--;
            end else if ($urandom_range(0, 3) == 0) begin
                rd_valid = 1;
            end
            if (wr_req) begin
                if (aw_w == 0) begin wr_addr_ok = 1; aw_ack = 1; end
                else aw_w--;
            end
            if (aw_done && wbeats < LW) begin
                if (w_w == 0) begin wr_beat_ok = 1; w_fire = 1; w_w = rnd(maxw); end
                else w_w--;
                if (early_b && wbeats == 3 && !early_sent) begin wr_done = 1; early_sent = 1; end
            end else if (wbeats == LW && !b_done) begin
                if (b_w == 0) begin wr_done = 1; b_fire = 1; end
                else b_w--;
            end
            #1;
            chk("rd_len", 32'(rd_len), LW - 1);
            if (rd_req) chk("rd_addr", rd_addr, ra);
            if (wr_req) chk("wr_addr", wr_addr, wa);
            if (rd_pend) begin
                chk("rd_req_held", 32'(rd_req), 1);
                chk("rd_addr_held", rd_addr, rd_addr_prev);
            end
            if (wr_pend) begin
                chk("wr_req_held", 32'(wr_req), 1);
                chk("wr_addr_held", wr_addr, wr_addr_prev);
            end
            if (ar_done) chk("rd_req_repeat", 32'(rd_req), 0);
            if (aw_done || !wb) chk("wr_req_unexpected", 32'(wr_req), 0);
`ifndef CACHE_MISS_WB_OVERLAP_EN
            if (wb && !b_done) chk("rd_req_before_wr_done", 32'(rd_req), 0);
`endif
            if (aw_done && wbeats < LW) begin
                chk("wr_idx", 32'(wr_idx), wbeats);
                chk("wr_last", 32'(wr_last), 32'(wbeats == LW - 1));
            end else begin
                chk("wr_last_outside", 32'(wr_last), 0);
            end
            chk("refill_we", 32'(refill_we), 32'(r_fire));
            if (r_fire) begin
                chk("refill_idx", 32'(refill_idx), rbeats);
                chk("refill_wdata", refill_wdata, dbase + 32'(rbeats));
            end
            if (refresh) begin
                n_ref++;
                chk("refresh_before_fill_done", rbeats, LW);
                if (wb) chk("refresh_before_wr_done", 32'(b_done), 1);
                if (tr < 0) tr = cyc;
            end
            if (tr >= 0 && cyc == tr + 2) begin
                chk("busy_end", 32'(busy), 0);
                fin = 1;
            end else begin
                chk("busy", 32'(busy), 32'(cyc >= 1));
            end
            rd_pend = rd_req && !rd_addr_ok; rd_addr_prev = rd_addr;
            wr_pend = wr_req && !wr_addr_ok; wr_addr_prev = wr_addr;
            if (ar_ack) ar_done = 1;
            if (r_fire) rbeats++;
            if (aw_ack) aw_done = 1;
            if (w_fire) wbeats++;
            if (b_fire) b_done = 1;
            @(posedge clk); #1;
            if (fin) break;
        end
        if (!fin) begin
            n_cmp++; n_err++;
            $display("FAIL miss_timeout: no completion within 400 cycles, raddr 0x%0h", ra);
        end
        chk("refresh_count", n_ref, 1);
        miss = 0; rd_addr_ok = 0; rd_valid = 0; wr_addr_ok = 0; wr_beat_ok = 0; wr_done = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("idle_busy", 32'(busy), 0);
            chk("idle_refresh", 32'(refresh), 0);
            chk("idle_reqs", 32'({rd_req, wr_req}), 0);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        wb;
        logic        hold;
        logic        early_b;
        logic [31:0] ra;
        logic [31:0] wa;
        int          exp_refresh;
    } vec_t;

    vec_t vecs[5];
    int   tr;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_1A40, 32'h0000_0000, 10};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0040_0020, 20};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_7FE0, 32'h0000_0000, 10};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h1234_5660, 32'h0040_0020, 20};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0BAD_F000, 32'hDEAD_BEE0, 20};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_miss(vecs[i].wb, vecs[i].hold, vecs[i].early_b, vecs[i].ra, vecs[i].wa,
                     0, 32'h0000_00A0, tr);
            chk("zero_wait_latency", tr, vecs[i].exp_refresh);
        end

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, wa, db;
            ra = $urandom & 32'hFFFF_FFE0;
            wa = $urandom & 32'hFFFF_FFE0;
            db = (i % 2 == 0) ? 32'h0000_00A0 : $urandom;
            run_miss(1'($urandom), 1'($urandom), 1'($urandom), ra, wa, 3, db, tr);
        end

        // reset asserted while refill beat 4 is on the bus
        miss = 1; write_back = 0; raddr = 32'h0000_3F00; rd_addr_ok = 1; rd_valid = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) miss = 0;
            if (c >= 1) rd_valid = 1;
            rd_data = 32'h0000_00B0 + 32'(c);
            if (c == 6) rst = 1;
            #1;
            if (c == 6) begin
                chk("pre_rst_refill_we", 32'(refill_we), 1);
                chk("pre_rst_refill_idx", 32'(refill_idx), 4);
            end
            @(posedge clk); #1;
        end
        rst = 0; rd_data = 32'hFFFF_FFFF;
        #1;
        check_reset_outputs();
        rd_valid = 0; rd_addr_ok = 0;
        @(posedge clk); #1;
        run_miss(1'b0, 1'b0, 1'b0, 32'h0000_1A40, 32'h0, 0, 32'h0000_00A0, tr);
        chk("post_rst_latency", tr, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
